// File: rtl/fp_execute_stage2.sv
// Floating-point execute stage 2: aligns the smaller add operand (guard/round/sticky)
// and forms the 32x32 significand product. Optional sticky logic: FP_STAGE2_STICKY_EN.
package defines;
  localparam int NUM_VECTOR_LANES = 16;

  typedef enum logic [5:0] {
    OP_ADD_I  = 6'h00,
    OP_MULL_I = 6'h07,
    OP_MULH_I = 6'h08,
    OP_FTOI   = 6'h1b,
    OP_MULH_U = 6'h1f,
    OP_ADD_F  = 6'h20,
    OP_MUL_F  = 6'h22
  } alu_op_t;

  typedef logic [NUM_VECTOR_LANES-1:0] vector_mask_t;
  typedef logic [1:0]                  local_thread_idx_t;
  typedef logic [3:0]                  subcycle_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       has_dest;
    logic [4:0] dest_reg;
    logic       dest_vector;
    logic [1:0] pipeline_sel;
  } decoded_instruction_t;
endpackage

module fp_execute_stage2
  import defines::*;
(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  fx1_instruction_valid,
  input  decoded_instruction_t                  fx1_instruction,
  input  vector_mask_t                          fx1_mask_value,
  input  local_thread_idx_t                     fx1_thread_idx,
  input  subcycle_t                             fx1_subcycle,
  input  logic [NUM_VECTOR_LANES-1:0]           fx1_result_is_inf,
  input  logic [NUM_VECTOR_LANES-1:0]           fx1_result_is_nan,
  input  logic [NUM_VECTOR_LANES-1:0]           fx1_logical_subtract,
  input  logic [NUM_VECTOR_LANES-1:0]           fx1_add_result_sign,
  input  logic [NUM_VECTOR_LANES-1:0]           fx1_mul_sign,
  input  logic [NUM_VECTOR_LANES-1:0][31:0]     fx1_significand_le,
  input  logic [NUM_VECTOR_LANES-1:0][31:0]     fx1_significand_se,
  input  logic [NUM_VECTOR_LANES-1:0][31:0]     fx1_multiplicand,
  input  logic [NUM_VECTOR_LANES-1:0][31:0]     fx1_multiplier,
  input  logic [NUM_VECTOR_LANES-1:0][5:0]      fx1_se_align_shift,
  input  logic [NUM_VECTOR_LANES-1:0][5:0]      fx1_ftoi_lshift,
  input  logic [NUM_VECTOR_LANES-1:0][7:0]      fx1_add_exponent,
  input  logic [NUM_VECTOR_LANES-1:0][7:0]      fx1_mul_exponent,
  output logic                                  fx2_instruction_valid,
  output decoded_instruction_t                  fx2_instruction,
  output vector_mask_t                          fx2_mask_value,
  output local_thread_idx_t                     fx2_thread_idx,
  output subcycle_t                             fx2_subcycle,
  output logic [NUM_VECTOR_LANES-1:0]           fx2_result_is_inf,
  output logic [NUM_VECTOR_LANES-1:0]           fx2_result_is_nan,
  output logic [NUM_VECTOR_LANES-1:0]           fx2_logical_subtract,
  output logic [NUM_VECTOR_LANES-1:0]           fx2_add_result_sign,
  output logic [NUM_VECTOR_LANES-1:0]           fx2_mul_sign,
  output logic [NUM_VECTOR_LANES-1:0]           fx2_guard,
  output logic [NUM_VECTOR_LANES-1:0]           fx2_round,
  output logic [NUM_VECTOR_LANES-1:0]           fx2_sticky,
  output logic [NUM_VECTOR_LANES-1:0][31:0]     fx2_significand_le,
  output logic [NUM_VECTOR_LANES-1:0][31:0]     fx2_significand_se,
  output logic [NUM_VECTOR_LANES-1:0][5:0]      fx2_ftoi_lshift,
  output logic [NUM_VECTOR_LANES-1:0][7:0]      fx2_add_exponent,
  output logic [NUM_VECTOR_LANES-1:0][7:0]      fx2_mul_exponent,
  output logic [NUM_VECTOR_LANES-1:0][63:0]     fx2_significand_product
);
  localparam int N = NUM_VECTOR_LANES;

  // Bits shifted out below the result land in a low extension of the window;
  // it only needs to hold every input bit when sticky is computed.
`ifdef FP_STAGE2_STICKY_EN
  localparam int unsigned LOW_W = 64;
`else
  localparam int unsigned LOW_W = 2;
`endif

  logic                  w_mul_signed;
  logic [N-1:0][31:0]    w_se_aligned;
  logic [N-1:0]          w_guard;
  logic [N-1:0]          w_round;
  logic [N-1:0]          w_sticky;
  logic [N-1:0][63:0]    w_product;

  assign w_mul_signed = (fx1_instruction.alu_op == OP_MULH_I);

  for (genvar l = 0; l < N; l++) begin : g_lane
    logic [LOW_W+31:0] w_window;
    logic [63:0]       w_mcand;
    logic [63:0]       w_mplier;

    always_comb begin
      w_window        = {fx1_significand_se[l], LOW_W'(0)} >> fx1_se_align_shift[l];
      w_se_aligned[l] = w_window[LOW_W +: 32];
      w_guard[l]      = w_window[LOW_W-1];
      w_round[l]      = w_window[LOW_W-2];
`ifdef FP_STAGE2_STICKY_EN
      w_sticky[l]     = |w_window[LOW_W-3:0];
`else
      w_sticky[l]     = 1'b0;
`endif
      // Sign-extending to 64 bits makes the truncated product correct for MULH_I.
      w_mcand      = {{32{w_mul_signed & fx1_multiplicand[l][31]}}, fx1_multiplicand[l]};
      w_mplier     = {{32{w_mul_signed & fx1_multiplier[l][31]}}, fx1_multiplier[l]};
      w_product[l] = w_mcand * w_mplier;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fx2_instruction_valid   <= 1'b0;
      fx2_instruction         <= '0;
      fx2_mask_value          <= '0;
      fx2_thread_idx          <= '0;
      fx2_subcycle            <= '0;
      fx2_result_is_inf       <= '0;
      fx2_result_is_nan       <= '0;
      fx2_logical_subtract    <= '0;
      fx2_add_result_sign     <= '0;
      fx2_mul_sign            <= '0;
      fx2_guard               <= '0;
      fx2_round               <= '0;
      fx2_sticky              <= '0;
      fx2_significand_le      <= '0;
      fx2_significand_se      <= '0;
      fx2_ftoi_lshift         <= '0;
      fx2_add_exponent        <= '0;
      fx2_mul_exponent        <= '0;
      fx2_significand_product <= '0;
    end else begin
      fx2_instruction_valid   <= fx1_instruction_valid;
      fx2_instruction         <= fx1_instruction;
      fx2_mask_value          <= fx1_mask_value;
      fx2_thread_idx          <= fx1_thread_idx;
      fx2_subcycle            <= fx1_subcycle;
      fx2_result_is_inf       <= fx1_result_is_inf;
      fx2_result_is_nan       <= fx1_result_is_nan;
      fx2_logical_subtract    <= fx1_logical_subtract;
      fx2_add_result_sign     <= fx1_add_result_sign;
      fx2_mul_sign            <= fx1_mul_sign;
      fx2_guard               <= w_guard;
      fx2_round               <= w_round;
      fx2_sticky              <= w_sticky;
      fx2_significand_le      <= fx1_significand_le;
      fx2_significand_se      <= w_se_aligned;
      fx2_ftoi_lshift         <= fx1_ftoi_lshift;
      fx2_add_exponent        <= fx1_add_exponent;
      fx2_mul_exponent        <= fx1_mul_exponent;
      fx2_significand_product <= w_product;
    end
  end
endmodule

// File: tb/tb_fp_execute_stage2.sv
// Bench for fp_execute_stage2: directed vector table, valid/reset sequences and
// random stimulus checked against a behavioural model of each output.
module tb_fp_execute_stage2;
  import defines::*;
  localparam int N = NUM_VECTOR_LANES;
`ifdef FP_STAGE2_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 fx1_instruction_valid;
  decoded_instruction_t fx1_instruction;
  vector_mask_t         fx1_mask_value;
  local_thread_idx_t    fx1_thread_idx;
  subcycle_t            fx1_subcycle;
  logic [N-1:0]         fx1_result_is_inf, fx1_result_is_nan, fx1_logical_subtract;
  logic [N-1:0]         fx1_add_result_sign, fx1_mul_sign;
  logic [N-1:0][31:0]   fx1_significand_le, fx1_significand_se, fx1_multiplicand, fx1_multiplier;
  logic [N-1:0][5:0]    fx1_se_align_shift, fx1_ftoi_lshift;
  logic [N-1:0][7:0]    fx1_add_exponent, fx1_mul_exponent;

  logic                 fx2_instruction_valid;
  decoded_instruction_t fx2_instruction;
  vector_mask_t         fx2_mask_value;
  local_thread_idx_t    fx2_thread_idx;
  subcycle_t            fx2_subcycle;
  logic [N-1:0]         fx2_result_is_inf, fx2_result_is_nan, fx2_logical_subtract;
  logic [N-1:0]         fx2_add_result_sign, fx2_mul_sign;
  logic [N-1:0]         fx2_guard, fx2_round, fx2_sticky;
  logic [N-1:0][31:0]   fx2_significand_le, fx2_significand_se;
  logic [N-1:0][5:0]    fx2_ftoi_lshift;
  logic [N-1:0][7:0]    fx2_add_exponent, fx2_mul_exponent;
  logic [N-1:0][63:0]   fx2_significand_product;

  fp_execute_stage2 dut (
    .clk(clk), .reset(reset),
    .fx1_instruction_valid(fx1_instruction_valid), .fx1_instruction(fx1_instruction),
    .fx1_mask_value(fx1_mask_value), .fx1_thread_idx(fx1_thread_idx), .fx1_subcycle(fx1_subcycle),
    .fx1_result_is_inf(fx1_result_is_inf), .fx1_result_is_nan(fx1_result_is_nan),
    .fx1_logical_subtract(fx1_logical_subtract), .fx1_add_result_sign(fx1_add_result_sign),
    .fx1_mul_sign(fx1_mul_sign), .fx1_significand_le(fx1_significand_le),
    .fx1_significand_se(fx1_significand_se), .fx1_multiplicand(fx1_multiplicand),
    .fx1_multiplier(fx1_multiplier), .fx1_se_align_shift(fx1_se_align_shift),
    .fx1_ftoi_lshift(fx1_ftoi_lshift), .fx1_add_exponent(fx1_add_exponent),
    .fx1_mul_exponent(fx1_mul_exponent),
    .fx2_instruction_valid(fx2_instruction_valid), .fx2_instruction(fx2_instruction),
    .fx2_mask_value(fx2_mask_value), .fx2_thread_idx(fx2_thread_idx), .fx2_subcycle(fx2_subcycle),
    .fx2_result_is_inf(fx2_result_is_inf), .fx2_result_is_nan(fx2_result_is_nan),
    .fx2_logical_subtract(fx2_logical_subtract), .fx2_add_result_sign(fx2_add_result_sign),
    .fx2_mul_sign(fx2_mul_sign), .fx2_guard(fx2_guard), .fx2_round(fx2_round),
    .fx2_sticky(fx2_sticky), .fx2_significand_le(fx2_significand_le),
    .fx2_significand_se(fx2_significand_se), .fx2_ftoi_lshift(fx2_ftoi_lshift),
    .fx2_add_exponent(fx2_add_exponent), .fx2_mul_exponent(fx2_mul_exponent),
    .fx2_significand_product(fx2_significand_product)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 valid;
    decoded_instruction_t instr;
    vector_mask_t         mask;
    local_thread_idx_t    thread;
    subcycle_t            subcycle;
    logic [N-1:0]         inf, nan, lsub, asign, msign, guard, round, sticky;
    logic [N-1:0][31:0]   le, se;
    logic [N-1:0][5:0]    ftoi;
    logic [N-1:0][7:0]    aexp, mexp;
    logic [N-1:0][63:0]   prod;
  } exp_t;

  typedef struct {
    logic [31:0] se;
    logic [5:0]  sh;
    logic [31:0] exp_se;
    logic        g, r, s;
    alu_op_t     op;
    logic [31:0] a, b;
    logic [63:0] prod;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  alu_op_t ops[7] = '{OP_ADD_I, OP_MULL_I, OP_MULH_I, OP_FTOI, OP_MULH_U, OP_ADD_F, OP_MUL_F};
  vec_t tbl[8];

  task automatic chk(input string name, input int lane, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lane %0d: got %h, expected %h", name, lane, act, exp);
    end
  endtask

  // Reference behaviour written from the arithmetic definition of each output.
  function automatic exp_t model();
    exp_t e;
    int s, sa, sb;
    logic [31:0] v;
    logic st;
    longint unsigned ua, ub;
    e.valid = fx1_instruction_valid;  e.instr = fx1_instruction;
    e.mask = fx1_mask_value;  e.thread = fx1_thread_idx;  e.subcycle = fx1_subcycle;
    e.inf = fx1_result_is_inf;  e.nan = fx1_result_is_nan;  e.lsub = fx1_logical_subtract;
    e.asign = fx1_add_result_sign;  e.msign = fx1_mul_sign;
    e.le = fx1_significand_le;  e.ftoi = fx1_ftoi_lshift;
    e.aexp = fx1_add_exponent;  e.mexp = fx1_mul_exponent;
    for (int l = 0; l < N; l++) begin
      v = fx1_significand_se[l];
      s = int'(fx1_se_align_shift[l]);
      e.se[l]    = (s >= 32) ? 32'd0 : v >> s;
      e.guard[l] = (s >= 1 && s <= 32) ? v[s-1] : 1'b0;
      e.round[l] = (s >= 2 && s <= 33) ? v[s-2] : 1'b0;
      st = 1'b0;
      for (int k = 0; k < 32; k++) if (k < s - 2) st = st | v[k];
      e.sticky[l] = STICKY_EN ? st : 1'b0;
      if (fx1_instruction.alu_op == OP_MULH_I) begin
        sa = fx1_multiplicand[l];
        sb = fx1_multiplier[l];
        e.prod[l] = 64'(longint'(sa) * longint'(sb));
      end else begin
        ua = 64'(fx1_multiplicand[l]);
        ub = 64'(fx1_multiplier[l]);
        e.prod[l] = ua * ub;
      end
    end
    return e;
  endfunction

  task automatic compare_all(input exp_t e);
    chk("valid", -1, 64'(fx2_instruction_valid), 64'(e.valid));
    chk("instruction", -1, 64'(fx2_instruction), 64'(e.instr));
    chk("mask", -1, 64'(fx2_mask_value), 64'(e.mask));
    chk("thread_idx", -1, 64'(fx2_thread_idx), 64'(e.thread));
    chk("subcycle", -1, 64'(fx2_subcycle), 64'(e.subcycle));
    chk("is_inf", -1, 64'(fx2_result_is_inf), 64'(e.inf));
    chk("is_nan", -1, 64'(fx2_result_is_nan), 64'(e.nan));
    chk("logical_sub", -1, 64'(fx2_logical_subtract), 64'(e.lsub));
    chk("add_sign", -1, 64'(fx2_add_result_sign), 64'(e.asign));
    chk("mul_sign", -1, 64'(fx2_mul_sign), 64'(e.msign));
    chk("guard", -1, 64'(fx2_guard), 64'(e.guard));
    chk("round", -1, 64'(fx2_round), 64'(e.round));
    chk("sticky", -1, 64'(fx2_sticky), 64'(e.sticky));
    for (int l = 0; l < N; l++) begin
      chk("sig_le", l, 64'(fx2_significand_le[l]), 64'(e.le[l]));
      chk("sig_se", l, 64'(fx2_significand_se[l]), 64'(e.se[l]));
      chk("ftoi_lshift", l, 64'(fx2_ftoi_lshift[l]), 64'(e.ftoi[l]));
      chk("add_exp", l, 64'(fx2_add_exponent[l]), 64'(e.aexp[l]));
      chk("mul_exp", l, 64'(fx2_mul_exponent[l]), 64'(e.mexp[l]));
      chk("product", l, fx2_significand_product[l], e.prod[l]);
    end
  endtask

  task automatic rand_inputs();
    fx1_instruction_valid        = 1'($urandom);
    fx1_instruction.alu_op       = ops[$urandom_range(0, 6)];
    fx1_instruction.has_dest     = 1'($urandom);
    fx1_instruction.dest_reg     = 5'($urandom);
    fx1_instruction.dest_vector  = 1'($urandom);
    fx1_instruction.pipeline_sel = 2'($urandom);
    fx1_mask_value       = 16'($urandom);
    fx1_thread_idx       = 2'($urandom);
    fx1_subcycle         = 4'($urandom);
    fx1_result_is_inf    = 16'($urandom);
    fx1_result_is_nan    = 16'($urandom);
    fx1_logical_subtract = 16'($urandom);
    fx1_add_result_sign  = 16'($urandom);
    fx1_mul_sign         = 16'($urandom);
    for (int l = 0; l < N; l++) begin
      fx1_significand_le[l] = $urandom;
      fx1_significand_se[l] = $urandom >> $urandom_range(0, 31);
      fx1_multiplicand[l]   = $urandom;
      fx1_multiplier[l]     = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      fx1_se_align_shift[l] = 6'($urandom_range(0, 63));
      fx1_ftoi_lshift[l]    = 6'($urandom);
      fx1_add_exponent[l]   = 8'($urandom);
      fx1_mul_exponent[l]   = 8'($urandom);
    end
  endtask

  task automatic step();
    exp_t e;
    e = model();
    @(posedge clk);
    #1;
    compare_all(e);
  endtask

  initial begin
    int L;
    logic pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    tbl[0] = '{32'h00800001, 6'd3,  32'h00100000, 1'b0, 1'b0, 1'b1, OP_MULH_I, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFFFFFFFFFE};
    tbl[1] = '{32'h00FFFFFF, 6'd27, 32'h00000000, 1'b0, 1'b0, 1'b1, OP_MULH_U, 32'hFFFFFFFF, 32'h00000002, 64'h00000001FFFFFFFE};
    tbl[2] = '{32'h80000000, 6'd0,  32'h80000000, 1'b0, 1'b0, 1'b0, OP_MULL_I, 32'h00000003, 32'h00000005, 64'h000000000000000F};
    tbl[3] = '{32'h80000000, 6'd32, 32'h00000000, 1'b1, 1'b0, 1'b0, OP_MUL_F,  32'h80000000, 32'h80000000, 64'h4000000000000000};
    tbl[4] = '{32'hFFFFFFFF, 6'd33, 32'h00000000, 1'b0, 1'b1, 1'b1, OP_MULH_I, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    tbl[5] = '{32'h00000001, 6'd63, 32'h00000000, 1'b0, 1'b0, 1'b1, OP_MULH_I, 32'h7FFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF80000001};
    tbl[6] = '{32'h00000006, 6'd2,  32'h00000001, 1'b1, 1'b0, 1'b0, OP_MULL_I, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    tbl[7] = '{32'h00000003, 6'd1,  32'h00000001, 1'b1, 1'b0, 1'b0, OP_MULH_U, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000};

    rand_inputs();
    #1 reset = 1'b0;
    #1 compare_all('0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed vectors, each placed in a different lane among random neighbours.
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      L = (i * 5 + 3) % N;
      fx1_significand_se[L]  = tbl[i].se;
      fx1_se_align_shift[L]  = tbl[i].sh;
      fx1_instruction.alu_op = tbl[i].op;
      fx1_multiplicand[L]    = tbl[i].a;
      fx1_multiplier[L]      = tbl[i].b;
      step();
      chk("tbl_se", L, 64'(fx2_significand_se[L]), 64'(tbl[i].exp_se));
      chk("tbl_guard", L, 64'(fx2_guard[L]), 64'(tbl[i].g));
      chk("tbl_round", L, 64'(fx2_round[L]), 64'(tbl[i].r));
      chk("tbl_sticky", L, 64'(fx2_sticky[L]), 64'(tbl[i].s & STICKY_EN));
      chk("tbl_product", L, fx2_significand_product[L], tbl[i].prod);
    end

    // Valid pulse train 1,0,1,1 with tagged thread/subcycle.
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      fx1_instruction_valid = pat[i];
      fx1_thread_idx = 2'(i);
      fx1_subcycle = 4'(i + 5);
      step();
      chk("valid_pat", i, 64'(fx2_instruction_valid), 64'(pat[i]));
      chk("thread_pat", i, 64'(fx2_thread_idx), 64'(i));
      chk("subcycle_pat", i, 64'(fx2_subcycle), 64'(i + 5));
    end

    // Reset mid-stream with an operation in flight.
    rand_inputs();
    fx1_instruction_valid = 1'b1;
    step();
    rand_inputs();
    fx1_instruction_valid = 1'b1;
    #2 reset = 1'b0;
    #1 compare_all('0);
    @(posedge clk);
    #1 compare_all('0);
    reset = 1'b1;
    rand_inputs();
    fx1_instruction_valid = 1'b1;
    step();
    chk("post_reset_valid", -1, 64'(fx2_instruction_valid), 64'(1));

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
